// File: rtl/lcg8_checker_if.sv
// Sample stream and status bundle for the LCG8 conformance checker.
// prev_data exists only when LCG8_CHK_REWIND_EN is defined.
interface lcg8_checker_if #(
   parameter int unsigned CNT_W = 16
);
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             locked;
   logic             match_pulse;
   logic             err_pulse;
   logic [CNT_W-1:0] ok_count;
   logic [CNT_W-1:0] err_count;
`ifdef LCG8_CHK_REWIND_EN
   logic [7:0]       prev_data;
`endif

   modport master (
      output clear,
      output in_valid,
      output in_data,
      input  in_ready,
      input  locked,
      input  match_pulse,
      input  err_pulse,
      input  ok_count,
`ifdef LCG8_CHK_REWIND_EN
      input  prev_data,
`endif
      input  err_count
   );

   modport slave (
      input  clear,
      input  in_valid,
      input  in_data,
      output in_ready,
      output locked,
      output match_pulse,
      output err_pulse,
      output ok_count,
`ifdef LCG8_CHK_REWIND_EN
      output prev_data,
`endif
      output err_count
   );
endinterface

// File: rtl/lcg8_checker.sv
// Tracks the x' = 13x+1 (mod 256) stream, counting matches and mismatches.
// Optional LCG8_CHK_REWIND_EN adds a prev_data register (inverse step).
module lcg8_checker #(
   parameter int unsigned RESYNC_LIMIT = 4,
   parameter int unsigned CNT_W        = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   lcg8_checker_if.slave bus
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [7:0] LIMIT = 8'(RESYNC_LIMIT);

   // 13x = 8x + 4x + x, kept to 8 bits
   function automatic logic [7:0] lcg_next(input logic [7:0] x);
      logic [7:0] x8;
      logic [7:0] x4;
      x8 = x << 3;
      x4 = x << 2;
      return 8'(x8 + x4 + x + 8'd1);
   endfunction

   state_t           state_q, state_d;
   logic             ready_q, ready_d;
   logic [7:0]       exp_q, exp_d;
   logic [7:0]       miss_q, miss_d;
   logic [7:0]       miss_inc;
   logic [CNT_W-1:0] ok_q, ok_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             match_q, match_d;
   logic             errp_q, errp_d;
   logic             accept;

   assign accept   = bus.in_valid && ready_q;
   assign miss_inc = 8'(miss_q + 8'd1);

   always_comb begin
      state_d = state_q;
      ready_d = 1'b1;
      exp_d   = exp_q;
      miss_d  = miss_q;
      ok_d    = ok_q;
      err_d   = err_q;
      match_d = 1'b0;
      errp_d  = 1'b0;
      if (bus.clear) begin
         state_d = HUNT;
         miss_d  = 8'd0;
         ok_d    = '0;
         err_d   = '0;
      end else if (accept) begin
         unique case (state_q)
            HUNT: begin
               exp_d   = lcg_next(bus.in_data);
               miss_d  = 8'd0;
               state_d = LOCKED;
            end
            LOCKED: begin
               if (bus.in_data == exp_q) begin
                  match_d = 1'b1;
                  miss_d  = 8'd0;
                  exp_d   = lcg_next(bus.in_data);
                  if (ok_q != '1) ok_d = ok_q + CNT_W'(1);
               end else begin
                  // sample treated as corrupted: advance from expected
                  errp_d = 1'b1;
                  miss_d = miss_inc;
                  exp_d  = lcg_next(exp_q);
                  if (err_q != '1) err_d = err_q + CNT_W'(1);
                  if (miss_inc == LIMIT) state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         ready_q <= 1'b0;
         exp_q   <= 8'd0;
         miss_q  <= 8'd0;
         ok_q    <= '0;
         err_q   <= '0;
         match_q <= 1'b0;
         errp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         exp_q   <= exp_d;
         miss_q  <= miss_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         match_q <= match_d;
         errp_q  <= errp_d;
      end
   end

   assign bus.in_ready    = ready_q;
   assign bus.locked      = (state_q == LOCKED);
   assign bus.match_pulse = match_q;
   assign bus.err_pulse   = errp_q;
   assign bus.ok_count    = ok_q;
   assign bus.err_count   = err_q;

`ifdef LCG8_CHK_REWIND_EN
   // 197 = 128+64+4+1 is the inverse of 13 mod 256
   function automatic logic [7:0] lcg_prev(input logic [7:0] d);
      logic [7:0] t;
      logic [7:0] t128;
      logic [7:0] t64;
      logic [7:0] t4;
      t    = 8'(d - 8'd1);
      t128 = t << 7;
      t64  = t << 6;
      t4   = t << 2;
      return 8'(t128 + t64 + t4 + t);
   endfunction

   logic [7:0] prev_q, prev_d;

   always_comb begin
      prev_d = prev_q;
      if (accept && !bus.clear) prev_d = lcg_prev(bus.in_data);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 8'd0;
      else        prev_q <= prev_d;
   end

   assign bus.prev_data = prev_q;
`endif

endmodule

// File: tb/tb_lcg8_checker.sv
// Directed bench for lcg8_checker with hand-computed LCG expectations.
module tb_lcg8_checker;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   lcg8_checker_if #(.CNT_W(16)) bus ();

   lcg8_checker #(
      .RESYNC_LIMIT(4),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear(input logic [7:0] d);
      @(negedge clk);
      bus.clear    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(posedge clk);
      #1;
      @(negedge clk);
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      #3;
      chk("rst_ready", 32'(bus.in_ready), 0);
      chk("rst_locked", 32'(bus.locked), 0);
      chk("rst_ok", 32'(bus.ok_count), 0);
      chk("rst_err", 32'(bus.err_count), 0);
      chk("rst_pulses", 32'({bus.match_pulse, bus.err_pulse}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst", 32'(bus.in_ready), 1);

      // 1,14,183,76 back-to-back
      send(8'd1);
      chk("seed_locked", 32'(bus.locked), 1);
      chk("seed_nopulse", 32'({bus.match_pulse, bus.err_pulse}), 0);
      chk("seed_ok", 32'(bus.ok_count), 0);
      send(8'd14);
      chk("m14_pulse", 32'(bus.match_pulse), 1);
      send(8'd183);
      chk("m183_pulse", 32'(bus.match_pulse), 1);
      send(8'd76);
      chk("m76_pulse", 32'(bus.match_pulse), 1);
      chk("seq_ok", 32'(bus.ok_count), 3);
      chk("seq_err", 32'(bus.err_count), 0);
      idle();
      chk("pulse_one_cycle", 32'(bus.match_pulse), 0);

      // clear with valid: 221 would have matched, must be discarded
      do_clear(8'd221);
      @(posedge clk);
      #1;
      chk("clr_ok", 32'(bus.ok_count), 0);
      chk("clr_locked", 32'(bus.locked), 0);
      chk("clr_pulse", 32'(bus.match_pulse), 0);

      // 1,14,99,76: one corrupted sample
      send(8'd1);
      send(8'd14);
      send(8'd99);
      chk("e99_pulse", 32'(bus.err_pulse), 1);
      chk("e99_match", 32'(bus.match_pulse), 0);
      chk("e99_locked", 32'(bus.locked), 1);
      send(8'd76);
      chk("e76_match", 32'(bus.match_pulse), 1);
      chk("e_ok", 32'(bus.ok_count), 2);
      chk("e_err", 32'(bus.err_count), 1);

      // resync after 4 consecutive misses
      do_clear(8'd0);
      send(8'd1);
      send(8'd0);
      send(8'd0);
      send(8'd0);
      chk("miss3_locked", 32'(bus.locked), 1);
      send(8'd0);
      chk("miss4_locked", 32'(bus.locked), 0);
      chk("miss4_err", 32'(bus.err_count), 4);
      chk("miss4_pulse", 32'(bus.err_pulse), 1);
      send(8'd5);
      chk("reseed_locked", 32'(bus.locked), 1);
      chk("reseed_nopulse", 32'({bus.match_pulse, bus.err_pulse}), 0);
      send(8'd66);
      chk("reseed_match", 32'(bus.match_pulse), 1);

      // wrap-around: 13*255+1=244, 13*244+1=101 (mod 256)
      do_clear(8'd0);
      send(8'd255);
      send(8'd244);
      send(8'd101);
      chk("wrap_ok", 32'(bus.ok_count), 2);
      chk("wrap_err", 32'(bus.err_count), 0);
      do_clear(8'd0);
      send(8'd0);
      send(8'd1);
      chk("zero_match", 32'(bus.match_pulse), 1);

      // reset between 14 and 183
      do_clear(8'd0);
      send(8'd1);
      send(8'd14);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ok", 32'(bus.ok_count), 0);
      chk("mid_rst_locked", 32'(bus.locked), 0);
      chk("mid_rst_pulse", 32'(bus.match_pulse), 0);
      chk("mid_rst_ready", 32'(bus.in_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'd183);
      chk("post_rst_pulse", 32'({bus.match_pulse, bus.err_pulse}), 0);
      chk("post_rst_locked", 32'(bus.locked), 1);
      send(8'd76);
      chk("post_rst_match", 32'(bus.match_pulse), 1);

`ifdef LCG8_CHK_REWIND_EN
      send(8'd14);
      chk("prev_14", 32'(bus.prev_data), 1);
      send(8'd0);
      chk("prev_0", 32'(bus.prev_data), 59);
      do_clear(8'd7);
      chk("prev_clr", 32'(bus.prev_data), 59);
      chk("prev_clr_ok", 32'(bus.ok_count), 0);
`endif

      idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
